// File: rtl/ram32_arb_pkg.sv
// Shared types and constants for the RAM32 bus arbiter.
package ram32_arb_pkg;
  localparam int AW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_HOST = 2'd1;
  localparam logic [1:0] GNT_DBUS = 2'd2;
  localparam logic [1:0] GNT_IBUS = 2'd3;
endpackage

// File: rtl/ram32_rr_pick.sv
// Combinational requester pick: host always first, then dbus/ibus by fixed or round-robin priority.
module ram32_rr_pick
  import ram32_arb_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic       host_req_i,
  input  logic       dbus_cyc_i,
  input  logic       ibus_cyc_i,
  input  logic       last_ibus_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = GNT_NONE;
    if (host_req_i)                    gnt_o = GNT_HOST;
    // On a tie the bus not served last wins; fixed mode always favours dbus.
    else if (dbus_cyc_i && ibus_cyc_i) gnt_o = (FAIR && !last_ibus_i) ? GNT_IBUS : GNT_DBUS;
    else if (dbus_cyc_i)               gnt_o = GNT_DBUS;
    else if (ibus_cyc_i)               gnt_o = GNT_IBUS;
  end
endmodule

// File: rtl/ram32_bus_arbiter.sv
// Shares the single RAM32 port between host byte port, SERV dbus and SERV ibus.
// Fixed IDLE -> ISSUE -> RESP sequence: one registered access per three cycles.
module ram32_bus_arbiter
  import ram32_arb_pkg::*;
#(
  parameter bit FAIR = 1'b1,
  parameter int AW   = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW+1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          host_ack,
  input  logic          ibus_cyc,
  input  logic [31:0]   ibus_adr,
  output logic [31:0]   ibus_rdt,
  output logic          ibus_ack,
  input  logic          dbus_cyc,
  input  logic [31:0]   dbus_adr,
  input  logic          dbus_we,
  input  logic [31:0]   dbus_dat,
  input  logic [3:0]    dbus_sel,
  output logic [31:0]   dbus_rdt,
  output logic          dbus_ack,
  output logic          ram_en,
  output logic [AW-1:0] ram_addr,
  output logic [3:0]    ram_we,
  output logic [31:0]   ram_di,
  input  logic [31:0]   ram_do,
  output logic [1:0]    grant
);
  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d, pick;
  logic          last_ibus_q, last_ibus_d;
  logic          en_q, en_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    we_q, we_d;
  logic [31:0]   di_q, di_d;
  logic [1:0]    lane_q, lane_d;
  logic          hrd_q, hrd_d;
  logic          oor_q, oor_d;
  logic [7:0]    hdata_q, hdata_d;
  logic          dbus_oor, ibus_oor, resp;
  logic          unused_adr_lsb;

  assign dbus_oor       = |dbus_adr[31:AW+2];
  assign ibus_oor       = |ibus_adr[31:AW+2];
  assign unused_adr_lsb = ^{dbus_adr[1:0], ibus_adr[1:0]};

  ram32_rr_pick #(.FAIR(FAIR)) u_pick (
    .host_req_i  (host_req),
    .dbus_cyc_i  (dbus_cyc),
    .ibus_cyc_i  (ibus_cyc),
    .last_ibus_i (last_ibus_q),
    .gnt_o       (pick)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_ibus_d = last_ibus_q;
    en_d        = en_q;
    addr_d      = addr_q;
    we_d        = we_q;
    di_d        = di_q;
    lane_d      = lane_q;
    hrd_d       = hrd_q;
    oor_d       = oor_q;
    hdata_d     = hdata_q;
    case (state_q)
      IDLE: if (pick != GNT_NONE) begin
        state_d = ISSUE;
        grant_d = pick;
        en_d    = 1'b1;
        oor_d   = 1'b0;
        hrd_d   = 1'b0;
        case (pick)
          GNT_HOST: begin
            addr_d = host_addr[AW+1:2];
            lane_d = host_addr[1:0];
            we_d   = host_we ? (4'b0001 << host_addr[1:0]) : 4'b0000;
            di_d   = {4{host_wdata}};
            hrd_d  = !host_we;
          end
          GNT_DBUS: begin
            last_ibus_d = 1'b0;
            addr_d      = dbus_adr[AW+1:2];
            we_d        = dbus_we ? dbus_sel : 4'b0000;
            di_d        = dbus_dat;
            // Out-of-range accesses run the full sequence with the RAM idle.
            if (dbus_oor) begin
              en_d  = 1'b0;
              we_d  = 4'b0000;
              oor_d = 1'b1;
            end
          end
          default: begin
            last_ibus_d = 1'b1;
            addr_d      = ibus_adr[AW+1:2];
            we_d        = 4'b0000;
            if (ibus_oor) begin
              en_d  = 1'b0;
              oor_d = 1'b1;
            end
          end
        endcase
      end
      ISSUE: begin
        state_d = RESP;
        en_d    = 1'b0;
        we_d    = 4'b0000;
      end
      RESP: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
        if (grant_q == GNT_HOST && hrd_q) hdata_d = ram_do[{lane_q, 3'b000} +: 8];
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= GNT_NONE;
      last_ibus_q <= 1'b1;
      en_q        <= 1'b0;
      addr_q      <= '0;
      we_q        <= '0;
      di_q        <= '0;
      lane_q      <= '0;
      hrd_q       <= 1'b0;
      oor_q       <= 1'b0;
      hdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_ibus_q <= last_ibus_d;
      en_q        <= en_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      di_q        <= di_d;
      lane_q      <= lane_d;
      hrd_q       <= hrd_d;
      oor_q       <= oor_d;
      hdata_q     <= hdata_d;
    end
  end

  assign resp       = (state_q == RESP);
  assign host_ack   = resp && (grant_q == GNT_HOST);
  assign dbus_ack   = resp && (grant_q == GNT_DBUS);
  assign ibus_ack   = resp && (grant_q == GNT_IBUS);
  assign dbus_rdt   = (dbus_ack && !oor_q) ? ram_do : 32'h0;
  assign ibus_rdt   = (ibus_ack && !oor_q) ? ram_do : 32'h0;
  assign host_rdata = hdata_q;
  assign ram_en     = en_q;
  assign ram_addr   = addr_q;
  assign ram_we     = we_q;
  assign ram_di     = di_q;
  assign grant      = grant_q;
endmodule

// File: tb/tb_ram32_bus_arbiter.sv
// Randomized bench for ram32_bus_arbiter against a transaction-level model of the shared RAM.
module tb_ram32_bus_arbiter;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AW+1:0] host_addr = '0;
  logic [7:0]    host_wdata = '0;
  logic          ibus_cyc = 1'b0, dbus_cyc = 1'b0, dbus_we = 1'b0;
  logic [31:0]   ibus_adr = '0, dbus_adr = '0, dbus_dat = '0;
  logic [3:0]    dbus_sel = '0;

  logic [7:0]    host_rdata;
  logic          host_ack, ibus_ack, dbus_ack, ram_en;
  logic [31:0]   ibus_rdt, dbus_rdt, ram_di, ram_do;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic [1:0]    grant;

  logic [7:0]    f0_host_rdata;
  logic          f0_host_ack, f0_ibus_ack, f0_dbus_ack, f0_ram_en;
  logic [31:0]   f0_ibus_rdt, f0_dbus_rdt, f0_ram_di;
  logic [AW-1:0] f0_ram_addr;
  logic [3:0]    f0_ram_we;
  logic [1:0]    f0_grant;

  ram32_bus_arbiter #(.FAIR(1'b1), .AW(AW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .ibus_cyc(ibus_cyc), .ibus_adr(ibus_adr), .ibus_rdt(ibus_rdt), .ibus_ack(ibus_ack),
    .dbus_cyc(dbus_cyc), .dbus_adr(dbus_adr), .dbus_we(dbus_we), .dbus_dat(dbus_dat),
    .dbus_sel(dbus_sel), .dbus_rdt(dbus_rdt), .dbus_ack(dbus_ack),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do),
    .grant(grant)
  );

  // Fixed-priority instance: only its arbitration order is examined.
  ram32_bus_arbiter #(.FAIR(1'b0), .AW(AW)) u_dut_fix (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(f0_host_rdata), .host_ack(f0_host_ack),
    .ibus_cyc(ibus_cyc), .ibus_adr(ibus_adr), .ibus_rdt(f0_ibus_rdt), .ibus_ack(f0_ibus_ack),
    .dbus_cyc(dbus_cyc), .dbus_adr(dbus_adr), .dbus_we(dbus_we), .dbus_dat(dbus_dat),
    .dbus_sel(dbus_sel), .dbus_rdt(f0_dbus_rdt), .dbus_ack(f0_dbus_ack),
    .ram_en(f0_ram_en), .ram_addr(f0_ram_addr), .ram_we(f0_ram_we), .ram_di(f0_ram_di),
    .ram_do(32'h0), .grant(f0_grant)
  );

  // RAM32 macro model: synchronous byte-write, registered read.
  logic [31:0] mem [32];
  logic        clr = 1'b1;
  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 32; k++) mem[k] <= '0;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++) if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_di[8*b +: 8];
      ram_do <= mem[ram_addr];
    end
  end

  int          errs = 0, checks = 0;
  logic [31:0] ref_mem [32];
  bit          m_last_ibus = 1'b1;
  logic [7:0]  ref_hr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_host(input logic we, input logic [AW+1:0] a, input logic [7:0] d);
    host_we = we; host_addr = a; host_wdata = d;
  endtask

  task automatic set_dbus(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    dbus_we = we; dbus_adr = a; dbus_dat = d; dbus_sel = s;
  endtask

  function automatic logic [31:0] rand_adr();
    logic [31:0] a;
    a = {25'd0, 7'($urandom)};
    if ($urandom_range(0, 4) == 0) a = a | (32'h80 << $urandom_range(0, 24));
    return a;
  endfunction

  task automatic idle_chk();
    chk("idle_grant", grant, 0);
    chk("idle_en", ram_en, 0);
    chk("idle_acks", {host_ack, dbus_ack, ibus_ack}, 0);
    chk("idle_rdt", dbus_rdt | ibus_rdt, 0);
    chk("host_rdata", host_rdata, ref_hr);
  endtask

  // Called at the falling edge of an IDLE cycle; returns at the falling edge of an IDLE cycle.
  task automatic run_round(input bit h, input bit d, input bit i);
    int order[$];
    bit ph, pd, pi;
    int who;
    logic [4:0] w;
    logic [1:0] ln;
    bit oor;
    logic [3:0] xwe;
    logic [31:0] xdi, xrd;
    ph = h; pd = d; pi = i; ln = '0;
    while (ph || pd || pi) begin
      if (ph) begin who = 1; ph = 1'b0; end
      else if (pd && pi) who = m_last_ibus ? 2 : 3;
      else who = pd ? 2 : 3;
      if (who == 2) begin pd = 1'b0; m_last_ibus = 1'b0; end
      if (who == 3) begin pi = 1'b0; m_last_ibus = 1'b1; end
      order.push_back(who);
    end
    host_req = h; dbus_cyc = d; ibus_cyc = i;
    foreach (order[j]) begin
      who = order[j];
      if (j > 0) begin @(posedge clk); @(negedge clk); idle_chk(); end
      case (who)
        1: begin
          w = host_addr[6:2]; ln = host_addr[1:0]; oor = 1'b0;
          xwe = host_we ? (4'b0001 << ln) : 4'b0000; xdi = {4{host_wdata}};
        end
        2: begin
          w = dbus_adr[6:2]; oor = |dbus_adr[31:7];
          xwe = (oor || !dbus_we) ? 4'b0000 : dbus_sel; xdi = dbus_dat;
        end
        default: begin
          w = ibus_adr[6:2]; oor = |ibus_adr[31:7]; xwe = 4'b0000; xdi = '0;
        end
      endcase
      xrd = oor ? 32'h0 : ref_mem[w];
      @(posedge clk); @(negedge clk);
      chk("issue_grant", grant, who);
      chk("issue_en", ram_en, !oor);
      chk("issue_we", ram_we, xwe);
      if (!oor) chk("issue_addr", ram_addr, w);
      if (xwe != 0) chk("issue_di", ram_di, xdi);
      chk("issue_noack", {host_ack, dbus_ack, ibus_ack}, 0);
      @(posedge clk); @(negedge clk);
      chk("resp_en", ram_en, 0);
      chk("resp_acks", {host_ack, dbus_ack, ibus_ack}, (who == 1) ? 4 : (who == 2) ? 2 : 1);
      if (who != 2) chk("resp_drdt", dbus_rdt, 0);
      else if (!dbus_we || oor) chk("resp_drdt", dbus_rdt, xrd);
      chk("resp_irdt", ibus_rdt, (who == 3) ? xrd : 32'h0);
      for (int b = 0; b < 4; b++) if (xwe[b]) ref_mem[w][8*b +: 8] = xdi[8*b +: 8];
      if (who == 1 && !host_we) ref_hr = xrd[8*ln +: 8];
      case (who)
        1:       host_req = 1'b0;
        2:       dbus_cyc = 1'b0;
        default: ibus_cyc = 1'b0;
      endcase
    end
    @(posedge clk); @(negedge clk);
    idle_chk();
  endtask

  initial begin
    int eg;
    for (int k = 0; k < 32; k++) ref_mem[k] = '0;
    // All three requesters already asserted while in reset.
    set_host(1'b0, 7'h00, 8'h00);
    set_dbus(1'b0, 32'h04, 32'h0, 4'hF);
    ibus_adr = 32'h08;
    host_req = 1'b1; dbus_cyc = 1'b1; ibus_cyc = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    chk("rst_en", ram_en, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_di", ram_di, 0);
    chk("rst_acks", {host_ack, dbus_ack, ibus_ack}, 0);
    chk("rst_rdt", dbus_rdt | ibus_rdt, 0);
    chk("rst_hrdata", host_rdata, 0);
    chk("rst_grant", grant, 0);
    rst_n = 1'b1;
    run_round(1, 1, 1);

    set_host(1'b1, 7'h06, 8'hA5);                   run_round(1, 0, 0);
    set_host(1'b0, 7'h06, 8'h00);                   run_round(1, 0, 0);
    set_dbus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);     run_round(0, 1, 0);
    ibus_adr = 32'h10;                              run_round(0, 0, 1);
    set_dbus(1'b1, 32'h14, 32'hFFFFFFFF, 4'hF);     run_round(0, 1, 0);
    set_dbus(1'b1, 32'h14, 32'h11223344, 4'b0011);  run_round(0, 1, 0);
    ibus_adr = 32'h14;                              run_round(0, 0, 1);
    set_dbus(1'b1, 32'h14, 32'hAAAAAAAA, 4'h0);     run_round(0, 1, 0);
    set_dbus(1'b0, 32'h14, 32'h0, 4'hF);            run_round(0, 1, 0);
    ibus_adr = 32'h100;                             run_round(0, 0, 1);
    set_dbus(1'b1, 32'h8000_0010, 32'h12345678, 4'hF); run_round(0, 1, 0);
    ibus_adr = 32'h10;                              run_round(0, 0, 1);

    for (int r = 0; r < 60; r++) begin
      set_host(1'($urandom), 7'($urandom), 8'($urandom));
      set_dbus(1'($urandom), rand_adr(), $urandom, 4'($urandom));
      ibus_adr = rand_adr();
      run_round(1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Continuous dbus+ibus contention straight after reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; m_last_ibus = 1'b1;
    set_dbus(1'b0, 32'h10, 32'h0, 4'hF);
    ibus_adr = 32'h14;
    dbus_cyc = 1'b1; ibus_cyc = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) begin @(posedge clk); @(negedge clk); chk("alt_idle", grant, 0); end
      eg = m_last_ibus ? 2 : 3;
      m_last_ibus = (eg == 3);
      @(posedge clk); @(negedge clk);
      chk("alt_grant", grant, eg);
      chk("fix_grant", f0_grant, 2);
      @(posedge clk); @(negedge clk);
      chk("alt_ack", {dbus_ack, ibus_ack}, (eg == 2) ? 2 : 1);
      chk("alt_rdt", (eg == 2) ? dbus_rdt : ibus_rdt, ref_mem[(eg == 2) ? 4 : 5]);
      chk("fix_ack", {f0_dbus_ack, f0_ibus_ack}, 2);
    end
    dbus_cyc = 1'b0; ibus_cyc = 1'b0;
    @(posedge clk); @(negedge clk);
    idle_chk();

    // Reset asserted during ISSUE of a dbus read.
    set_dbus(1'b0, 32'h14, 32'h0, 4'hF);
    dbus_cyc = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mr_issue_en", ram_en, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_en", ram_en, 0);
    chk("mr_grant", grant, 0);
    chk("mr_we", ram_we, 0);
    chk("mr_addr", ram_addr, 0);
    chk("mr_di", ram_di, 0);
    chk("mr_ack", dbus_ack, 0);
    @(posedge clk); @(negedge clk);
    chk("mr_noack", {host_ack, dbus_ack, ibus_ack}, 0);
    dbus_cyc = 1'b0; rst_n = 1'b1; m_last_ibus = 1'b1; ref_hr = '0;
    @(posedge clk); @(negedge clk);
    idle_chk();
    run_round(0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
